// File: rtl/sha1_arbiter.sv
// Two-client SHA-1 core arbiter: grants whole sessions, 1-cycle registered command path.
// rdy gates commands while busy; commands outside rdy are dropped and flagged sticky in err.
module sha1_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   cmd_init,
    input  logic [1:0]   cmd_next,
    input  logic [511:0] blk0,
    input  logic [511:0] blk1,
    output logic [1:0]   gnt,
    output logic [1:0]   rdy,
    output logic [1:0]   done,
    output logic [159:0] digest,
    output logic [1:0]   err,
    output logic         timeout,
    output logic         sha1_init,
    output logic         sha1_next,
    output logic [511:0] sha1_block,
    input  logic         sha1_ready,
    input  logic [159:0] sha1_digest
);
    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic             owner;
    logic             last;
    logic             inflight;
    logic             rdy_q;
    logic [CNT_W-1:0] wd;

    logic             cmp;
    logic             busy;
    logic             acc;
    logic             win;
    logic             wd_fire;
    logic [1:0]       cmd_any;
    logic [CNT_W-1:0] wd_inc;

    // Completion is the rising edge of sha1_ready; it frees the owner in the same cycle.
    assign cmp     = inflight & sha1_ready & ~rdy_q;
    assign busy    = inflight & ~cmp;
    assign rdy     = (state == OWNED && !busy && sha1_ready) ? gnt : 2'b00;
    assign done    = cmp ? gnt : 2'b00;
    assign digest  = sha1_digest;

    assign cmd_any = cmd_init | cmd_next;
    assign acc     = |(rdy & cmd_any);
    assign win     = (req == 2'b11) ? ~last : req[1];
    assign wd_inc  = wd + 1'b1;
    assign wd_fire = busy && (wd_inc == WD_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            inflight   <= 1'b0;
            rdy_q      <= 1'b1;
            wd         <= '0;
            gnt        <= 2'b00;
            err        <= 2'b00;
            timeout    <= 1'b0;
            sha1_init  <= 1'b0;
            sha1_next  <= 1'b0;
            sha1_block <= '0;
        end else begin
            rdy_q     <= sha1_ready;
            err       <= err | (cmd_any & ~rdy);
            sha1_init <= acc & cmd_init[owner];
            sha1_next <= acc & ~cmd_init[owner];
            if (acc) begin
                sha1_block <= owner ? blk1 : blk0;
            end

            if (acc) begin
                inflight <= 1'b1;
                wd       <= '0;
            end else if (cmp) begin
                inflight <= 1'b0;
            end else if (busy) begin
                wd <= wd_inc;
                if (wd_fire) begin
                    inflight <= 1'b0;
                    timeout  <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (sha1_ready && (req != 2'b00)) begin
                        owner <= win;
                        last  <= win;
                        gnt   <= win ? 2'b10 : 2'b01;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    if (!req[owner]) begin
                        if (acc || busy) begin
                            state <= DRAIN;
                        end else begin
                            state <= IDLE;
                            gnt   <= 2'b00;
                        end
                    end
                end
                DRAIN: begin
                    if (cmp) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase

            // A hung core abandons the session regardless of state.
            if (wd_fire) begin
                state <= IDLE;
                gnt   <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_sha1_arbiter.sv
// Directed bench for sha1_arbiter with a behavioural SHA-1 core (80-cycle busy window).
module tb_sha1_arbiter;
    typedef logic [511:0] w_t;

    localparam logic [159:0] DIG    = 160'h0123456789abcdef0123456789abcdef01234567;
    localparam w_t           SECRET = {16{32'hdeadbeef}};
    localparam w_t           IPAD   = {64{8'h36}};
    localparam w_t           OPAD   = {64{8'h5c}};
    localparam w_t           B1_BAD = {16{32'hbad0b10c}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [1:0]   cmd_init = 2'b00;
    logic [1:0]   cmd_next = 2'b00;
    logic [511:0] blk0 = '0;
    logic [511:0] blk1 = '0;
    logic [1:0]   gnt, rdy, done, err;
    logic [159:0] digest;
    logic         timeout, sha1_init, sha1_next;
    logic [511:0] sha1_block;
    logic         sha1_ready = 1'b1;
    logic [159:0] sha1_digest = DIG;

    sha1_arbiter #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_init(cmd_init), .cmd_next(cmd_next),
        .blk0(blk0), .blk1(blk1), .gnt(gnt), .rdy(rdy), .done(done), .digest(digest),
        .err(err), .timeout(timeout), .sha1_init(sha1_init), .sha1_next(sha1_next),
        .sha1_block(sha1_block), .sha1_ready(sha1_ready), .sha1_digest(sha1_digest)
    );

    always #5 clk = ~clk;

    // Core model: ready drops the cycle after a command is sampled, returns 80 cycles later.
    int   core_cnt = 0;
    logic hang = 1'b0;
    always @(posedge clk) begin
        if (sha1_init || sha1_next) begin
            sha1_ready <= 1'b0;
            core_cnt   <= 80;
        end else if (!sha1_ready && !hang) begin
            if (core_cnt <= 1) sha1_ready <= 1'b1;
            else core_cnt <= core_cnt - 1;
        end
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mon_init = 0;
    int   mon_done = 0;
    logic mon_g1 = 1'b0;
    logic mon_blk1 = 1'b0;
    int   cyc;

    task automatic chk(input string tag, input w_t got, input w_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mon_init += int'(sha1_init);
        if (done != 2'b00) mon_done++;
        mon_g1 = mon_g1 | gnt[1];
        if (sha1_init && sha1_block == B1_BAD) mon_blk1 = 1'b1;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done == 2'b00 && n < 300) begin
            step();
            n++;
        end
        chk(tag, w_t'(done != 2'b00), w_t'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_gnt", w_t'(gnt), w_t'(2'b00));
        chk("rst_rdy", w_t'(rdy), w_t'(2'b00));
        chk("rst_err", w_t'({err, timeout}), w_t'(3'b000));
        chk("rst_cmd", w_t'({sha1_init, sha1_next, done}), w_t'(4'b0000));
        chk("rst_blk", sha1_block, w_t'(0));
        chk("digest", w_t'(digest), w_t'(DIG));
        rst = 1'b1;

        // Single session: requester 0 hashes secret^ipad
        req = 2'b01;
        step();
        chk("s_gnt", w_t'(gnt), w_t'(2'b01));
        chk("s_rdy", w_t'(rdy), w_t'(2'b01));
        blk0 = SECRET ^ IPAD;
        cmd_init = 2'b01;
        mon_init = 0;
        mon_done = 0;
        step();
        cmd_init = 2'b00;
        chk("s_init", w_t'({sha1_init, sha1_next}), w_t'(2'b10));
        chk("s_blk", sha1_block, SECRET ^ IPAD);
        chk("s_busy_rdy", w_t'(rdy), w_t'(2'b00));
        wait_done("s_done_seen", cyc);
        chk("s_done", w_t'(done), w_t'(2'b01));
        chk("s_done_rdy", w_t'(rdy), w_t'(2'b01));
        chk("s_latency", w_t'(cyc), w_t'(81));
        step();
        chk("s_done_pulse", w_t'(done), w_t'(2'b00));
        chk("s_init_cnt", w_t'(mon_init), w_t'(1));
        chk("s_done_cnt", w_t'(mon_done), w_t'(1));
        req = 2'b00;
        step();
        chk("s_release", w_t'(gnt), w_t'(2'b00));

        // Tie and round-robin, starting from reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        req = 2'b11;
        step();
        chk("rr_tie0", w_t'(gnt), w_t'(2'b01));
        req = 2'b10;
        step();
        chk("rr_idle0", w_t'(gnt), w_t'(2'b00));
        req = 2'b11;
        step();
        chk("rr_tie1", w_t'(gnt), w_t'(2'b10));
        req = 2'b01;
        step();
        chk("rr_idle1", w_t'(gnt), w_t'(2'b00));
        req = 2'b11;
        step();
        chk("rr_tie2", w_t'(gnt), w_t'(2'b01));
        req = 2'b00;
        step();

        // No interleave: requester 1 intrudes during an HMAC inner hash
        req = 2'b01;
        step();
        mon_g1 = 1'b0;
        mon_blk1 = 1'b0;
        blk0 = SECRET ^ IPAD;
        cmd_init = 2'b01;
        step();
        cmd_init = 2'b00;
        req = 2'b11;
        blk1 = B1_BAD;
        cmd_init = 2'b10;
        step();
        cmd_init = 2'b00;
        chk("ni_err", w_t'(err), w_t'(2'b10));
        chk("ni_gnt", w_t'(gnt), w_t'(2'b01));
        wait_done("ni_done1_seen", cyc);
        blk0 = SECRET ^ OPAD;
        cmd_next = 2'b01;
        step();
        cmd_next = 2'b00;
        chk("ni_next", w_t'({sha1_init, sha1_next}), w_t'(2'b01));
        chk("ni_next_blk", sha1_block, SECRET ^ OPAD);
        wait_done("ni_done2_seen", cyc);
        chk("ni_done2", w_t'(done), w_t'(2'b01));
        req = 2'b10;
        step();
        chk("ni_gap", w_t'(gnt), w_t'(2'b00));
        chk("ni_no_g1_early", w_t'(mon_g1), w_t'(1'b0));
        step();
        chk("ni_g1", w_t'(gnt), w_t'(2'b10));
        chk("ni_no_blk1", w_t'(mon_blk1), w_t'(1'b0));
        chk("ni_err_sticky", w_t'(err), w_t'(2'b10));

        // Drain: requester 1 releases one cycle after its command is accepted
        blk1 = OPAD;
        cmd_init = 2'b10;
        step();
        cmd_init = 2'b00;
        chk("dr_blk", sha1_block, OPAD);
        req = 2'b00;
        step();
        chk("dr_gnt_held", w_t'(gnt), w_t'(2'b10));
        chk("dr_rdy", w_t'(rdy), w_t'(2'b00));
        wait_done("dr_done_seen", cyc);
        chk("dr_done", w_t'({done, gnt}), w_t'(4'b1010));
        step();
        chk("dr_gnt_clr", w_t'(gnt), w_t'(2'b00));

        // Watchdog: core never returns ready after sha1_next
        req = 2'b01;
        step();
        chk("wd_gnt", w_t'(gnt), w_t'(2'b01));
        hang = 1'b1;
        blk0 = IPAD;
        cmd_next = 2'b01;
        step();
        cmd_next = 2'b00;
        chk("wd_next", w_t'(sha1_next), w_t'(1'b1));
        mon_done = 0;
        repeat (254) step();
        chk("wd_not_yet", w_t'(timeout), w_t'(1'b0));
        step();
        chk("wd_fire", w_t'(timeout), w_t'(1'b1));
        chk("wd_gnt_clr", w_t'(gnt), w_t'(2'b00));
        chk("wd_no_done", w_t'(mon_done), w_t'(0));
        req = 2'b10;
        hang = 1'b0;
        cyc = 0;
        while (gnt == 2'b00 && cyc < 300) begin
            step();
            cyc++;
        end
        chk("wd_regrant", w_t'(gnt), w_t'(2'b10));
        chk("wd_sticky", w_t'(timeout), w_t'(1'b1));

        // Reset while a command is in flight
        cmd_init = 2'b10;
        step();
        cmd_init = 2'b00;
        chk("rm_init", w_t'(sha1_init), w_t'(1'b1));
        rst = 1'b0;
        step();
        chk("rm_gnt", w_t'({gnt, rdy, done}), w_t'(6'b000000));
        chk("rm_flags", w_t'({err, timeout}), w_t'(3'b000));
        chk("rm_cmd", w_t'({sha1_init, sha1_next}), w_t'(2'b00));
        chk("rm_blk", sha1_block, w_t'(0));
        rst = 1'b1;
        req = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
